// File: rtl/pll_seq_pkg.sv
// Shared state encodings, default timing constants and counter sizing for the PLL lock sequencer.
package pll_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_PULSE  = 3'd0;
   localparam state_t ST_WAIT   = 3'd1;
   localparam state_t ST_STABLE = 3'd2;
   localparam state_t ST_RUN    = 3'd3;
   localparam state_t ST_FAIL   = 3'd4;

   localparam int unsigned RST_PULSE_CYCLES_DEF    = 16;
   localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 50000;
   localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1024;
   localparam int unsigned MAX_RETRIES_DEF         = 3;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-high reset to zero.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock wait with bounded retries, and lock-qualified release of system reset.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYCLES    = RST_PULSE_CYCLES_DEF,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
   parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
   parameter int unsigned MAX_RETRIES         = MAX_RETRIES_DEF
) (
   input  logic                             refclk,
   input  logic                             rst,
   input  logic                             pll_locked,
   input  logic                             relock_req,
   output logic                             pll_rst,
   output logic                             sys_rst,
   output logic                             ready,
   output logic                             fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

   localparam int unsigned PW = cnt_width(RST_PULSE_CYCLES);
   localparam int unsigned TW = cnt_width(LOCK_TIMEOUT_CYCLES);
   localparam int unsigned SW = cnt_width(LOCK_STABLE_CYCLES);
   localparam int unsigned CW = (PW > TW) ? ((PW > SW) ? PW : SW) : ((TW > SW) ? TW : SW);
   localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

   logic          lk;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d, retry_inc;
   logic          pll_rst_q, sys_rst_q, ready_q, fail_q;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk)
   );

   assign retry_inc = (retry_q == RETRY_LIMIT) ? retry_q : retry_q + 1'b1;

   // One counter serves the pulse, timeout and stable phases; it is cleared on every state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      if (relock_req) begin
         state_d = ST_PULSE;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_PULSE: begin
               if (cnt_q >= PULSE_LAST) begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (lk) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q >= TIMEOUT_LAST) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PULSE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_STABLE: begin
               if (!lk) begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end else if (cnt_q >= STABLE_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lk) begin
                  state_d = ST_PULSE;
                  cnt_d   = '0;
               end
            end
            ST_FAIL: begin
               cnt_d = '0;
            end
            default: begin
               state_d = ST_PULSE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PULSE;
         cnt_q     <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         pll_rst_q <= (state_d == ST_PULSE) || (state_d == ST_FAIL);
         sys_rst_q <= (state_d != ST_RUN);
         ready_q   <= (state_d == ST_RUN);
         fail_q    <= (state_d == ST_FAIL);
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a phase-level reference model checked every cycle.
module tb_pll_lock_sequencer;

   localparam int unsigned P_PULSE   = 4;
   localparam int unsigned P_TIMEOUT = 20;
   localparam int unsigned P_STABLE  = 8;
   localparam int unsigned P_RETRIES = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, sys_rst, ready, fail;
   logic [1:0] retry_cnt;

   int n_checks = 0;
   int n_pass = 0;

   pll_lock_sequencer #(
      .RST_PULSE_CYCLES    (P_PULSE),
      .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
      .LOCK_STABLE_CYCLES  (P_STABLE),
      .MAX_RETRIES         (P_RETRIES)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fail       (fail),
      .retry_cnt  (retry_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
   endtask

   // Reference model: what the sequencer is doing, how long it has been at it, and lock history.
   typedef enum int {M_RESETTING, M_AWAIT_LOCK, M_SETTLING, M_RUNNING, M_GAVE_UP} phase_e;
   phase_e phase = M_RESETTING;
   int     elapsed = 0;
   int     timeouts = 0;
   logic   seen1 = 1'b0, seen2 = 1'b0;

   always @(posedge refclk or posedge rst) begin
      logic lock_now;
      if (rst) begin
         phase = M_RESETTING; elapsed = 0; timeouts = 0; seen1 = 1'b0; seen2 = 1'b0;
      end else begin
         lock_now = seen2;
         seen2 = seen1;
         seen1 = pll_locked;
         if (relock_req) begin
            phase = M_RESETTING; elapsed = 0; timeouts = 0;
         end else begin
            elapsed++;
            if (phase == M_RESETTING && elapsed == P_PULSE) begin
               phase = M_AWAIT_LOCK; elapsed = 0;
            end else if (phase == M_AWAIT_LOCK && lock_now) begin
               phase = M_SETTLING; elapsed = 0;
            end else if (phase == M_AWAIT_LOCK && elapsed == P_TIMEOUT) begin
               timeouts++;
               phase = (timeouts == P_RETRIES) ? M_GAVE_UP : M_RESETTING;
               elapsed = 0;
            end else if (phase == M_SETTLING && !lock_now) begin
               phase = M_AWAIT_LOCK; elapsed = 0;
            end else if (phase == M_SETTLING && elapsed == P_STABLE) begin
               phase = M_RUNNING; elapsed = 0; timeouts = 0;
            end else if (phase == M_RUNNING && !lock_now) begin
               phase = M_RESETTING; elapsed = 0;
            end
         end
      end
   end

   always @(negedge refclk) begin
      check("model pll_rst", int'(pll_rst), int'(phase == M_RESETTING || phase == M_GAVE_UP));
      check("model sys_rst", int'(sys_rst), int'(phase != M_RUNNING));
      check("model ready", int'(ready), int'(phase == M_RUNNING));
      check("model fail", int'(fail), int'(phase == M_GAVE_UP));
      check("model retry_cnt", int'(retry_cnt), timeouts);
      if (!ready) check("reset held outside run", int'(pll_rst | sys_rst), 1);
   end

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic count_while_pll_rst(output int n);
      n = 0;
      while (pll_rst && n < 200) begin tick(); n++; end
   endtask

   task automatic count_while_sys_rst(output int n, output int saw_prst);
      n = 0;
      saw_prst = 0;
      while (sys_rst && n < 200) begin
         tick(); n++;
         if (pll_rst) saw_prst = 1;
      end
   endtask

   initial begin
      int n, n2, saw;
      repeat (3) tick();
      check("reset pll_rst", int'(pll_rst), 1);
      check("reset sys_rst", int'(sys_rst), 1);
      check("reset ready", int'(ready), 0);
      check("reset fail", int'(fail), 0);
      check("reset retry_cnt", int'(retry_cnt), 0);

      // Normal bring-up
      rst = 1'b0;
      count_while_pll_rst(n);
      check("bringup pll_rst width", n, 4);
      repeat (6) tick();
      pll_locked = 1'b1;
      count_while_sys_rst(n, saw);
      check("bringup lock-to-release", n, 11);
      check("bringup ready", int'(ready), 1);
      check("bringup retry_cnt", int'(retry_cnt), 0);

      // Loss of lock in RUN
      pll_locked = 1'b0;
      n = 0;
      while (!sys_rst && n < 50) begin tick(); n++; end
      check("loss sys_rst latency", n, 3);
      check("loss ready", int'(ready), 0);
      count_while_pll_rst(n);
      check("loss pll_rst width", n, 4);

      // Lock glitch while settling
      pll_locked = 1'b1;
      repeat (5) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      count_while_sys_rst(n, saw);
      check("glitch release after second rise", n, 11);
      check("glitch no pll_rst pulse", saw, 0);

      // Timeouts, retries, FAIL
      pll_locked = 1'b0;
      n = 0;
      while (!pll_rst && n < 50) begin tick(); n++; end
      count_while_pll_rst(n);
      check("retry pulse1 width", n, 4);
      n = 0;
      while (!pll_rst && n < 100) begin tick(); n++; end
      check("retry wait1 length", n, 20);
      check("retry count 1", int'(retry_cnt), 1);
      count_while_pll_rst(n);
      check("retry pulse2 width", n, 4);
      n = 0;
      while (!pll_rst && n < 100) begin tick(); n++; end
      check("retry wait2 length", n, 20);
      check("retry count 2", int'(retry_cnt), 2);
      check("fail asserted", int'(fail), 1);
      repeat (10) tick();
      check("fail held", int'(fail), 1);
      check("fail pll_rst held", int'(pll_rst), 1);

      // Recovery from FAIL
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check("relock retry_cnt", int'(retry_cnt), 0);
      check("relock fail", int'(fail), 0);
      count_while_pll_rst(n);
      check("relock pll_rst width", n, 4);
      pll_locked = 1'b1;
      count_while_sys_rst(n, saw);
      check("relock lock-to-release", n, 11);
      check("relock ready", int'(ready), 1);

      // Async reset while settling
      pll_locked = 1'b0;
      n = 0;
      while (!pll_rst && n < 50) begin tick(); n++; end
      count_while_pll_rst(n);
      pll_locked = 1'b1;
      repeat (5) tick();
      check("pre-reset still settling", int'(sys_rst), 1);
      rst = 1'b1;
      #1;
      check("async pll_rst", int'(pll_rst), 1);
      check("async sys_rst", int'(sys_rst), 1);
      check("async ready", int'(ready), 0);
      check("async fail", int'(fail), 0);
      @(negedge refclk);
      #1;
      rst = 1'b0;
      count_while_pll_rst(n);
      check("restart pll_rst width", n, 4);
      n2 = 0;
      while (!ready && n2 < 100) begin tick(); n2++; end
      check("restart wait-to-run", n2, 9);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

endmodule
